// File: rtl/rv_imm_pkg.sv
// Shared RV opcode constants and the immediate format encoding used by the decode-stage immediate path.
package rv_imm_pkg;

  localparam logic [6:0] OPC_LUI     = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC   = 7'b0010111;
  localparam logic [6:0] OPC_JAL     = 7'b1101111;
  localparam logic [6:0] OPC_JALR    = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH  = 7'b1100011;
  localparam logic [6:0] OPC_LOAD    = 7'b0000011;
  localparam logic [6:0] OPC_STORE   = 7'b0100011;
  localparam logic [6:0] OPC_OPIMM   = 7'b0010011;
  localparam logic [6:0] OPC_OPIMM32 = 7'b0011011;

  typedef enum logic [2:0] {
    FMT_NONE = 3'd0,
    FMT_I    = 3'd1,
    FMT_S    = 3'd2,
    FMT_B    = 3'd3,
    FMT_U    = 3'd4,
    FMT_J    = 3'd5,
    FMT_SH   = 3'd6
  } imm_fmt_t;

endpackage

// File: rtl/imm_decode.sv
// Combinational RV immediate decoder: format select, bit assembly, sign/zero extension to XLEN.
// Illegal encodings force a zero immediate and FMT_NONE so downstream never sees partial decode.
module imm_decode
  import rv_imm_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [31:0]     instr_i,
  output logic [XLEN-1:0] imm_o,
  output imm_fmt_t        fmt_o,
  output logic            illegal_o
);

  if (XLEN != 32 && XLEN != 64) begin : g_bad_xlen
    $error("imm_decode: XLEN must be 32 or 64");
  end

  logic [6:0]  opc;
  logic        is_shift;
  logic [5:0]  shamt;
  logic [31:0] imm32;
  imm_fmt_t    fmt;
  logic        illegal;

  assign opc      = instr_i[6:0];
  assign is_shift = (instr_i[14:12] == 3'b001) || (instr_i[14:12] == 3'b101);

  always_comb begin
    fmt     = FMT_NONE;
    illegal = 1'b0;
    shamt   = 6'd0;
    case (opc)
      OPC_LUI, OPC_AUIPC: fmt = FMT_U;
      OPC_JAL:            fmt = FMT_J;
      OPC_JALR, OPC_LOAD: fmt = FMT_I;
      OPC_BRANCH:         fmt = FMT_B;
      OPC_STORE:          fmt = FMT_S;
      OPC_OPIMM: begin
        if (is_shift) begin
          fmt = FMT_SH;
          // RV32 has no shamt[5]; setting it is a reserved encoding
          if (XLEN == 64) begin
            shamt = instr_i[25:20];
          end else begin
            shamt   = {1'b0, instr_i[24:20]};
            illegal = instr_i[25];
          end
        end else begin
          fmt = FMT_I;
        end
      end
      OPC_OPIMM32: begin
        if (XLEN != 64) begin
          illegal = 1'b1;
        end else if (is_shift) begin
          fmt     = FMT_SH;
          shamt   = {1'b0, instr_i[24:20]};
          illegal = instr_i[25];
        end else begin
          fmt = FMT_I;
        end
      end
      default: illegal = 1'b1;
    endcase
  end

  always_comb begin
    imm32 = 32'd0;
    case (fmt)
      FMT_I:   imm32 = {{20{instr_i[31]}}, instr_i[31:20]};
      FMT_S:   imm32 = {{20{instr_i[31]}}, instr_i[31:25], instr_i[11:7]};
      FMT_B:   imm32 = {{19{instr_i[31]}}, instr_i[31], instr_i[7], instr_i[30:25], instr_i[11:8], 1'b0};
      FMT_U:   imm32 = {instr_i[31:12], 12'd0};
      FMT_J:   imm32 = {{11{instr_i[31]}}, instr_i[31], instr_i[19:12], instr_i[20], instr_i[30:21], 1'b0};
      default: imm32 = 32'd0;
    endcase
  end

  always_comb begin
    imm_o       = {XLEN{imm32[31]}};
    imm_o[31:0] = imm32;
    if (fmt == FMT_SH) begin
      imm_o      = '0;
      imm_o[5:0] = shamt;
    end
    fmt_o     = fmt;
    illegal_o = illegal;
    if (illegal) begin
      imm_o = '0;
      fmt_o = FMT_NONE;
    end
  end

endmodule

// File: rtl/imm_gen_pipe.sv
// Pipelined immediate generator: decode then a 2-entry skid buffer, 1-cycle latency, full rate.
// in_ready comes from registered occupancy only, so there is no combinational path from out_ready.
module imm_gen_pipe
  import rv_imm_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int TAG_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      in_instr,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [XLEN-1:0]  out_imm,
  output logic [2:0]       out_fmt,
  output logic             out_illegal,
  output logic [TAG_W-1:0] out_tag
);

  typedef struct packed {
    logic [XLEN-1:0]  imm;
    imm_fmt_t         fmt;
    logic             illegal;
    logic [TAG_W-1:0] tag;
  } imm_res_t;

  localparam logic [1:0] ST_EMPTY = 2'd0;
  localparam logic [1:0] ST_ONE   = 2'd1;
  localparam logic [1:0] ST_FULL  = 2'd2;

  logic [1:0]      state_q, state_d;
  imm_res_t        m_q, m_d, k_q, k_d;
  imm_res_t        dec_res;
  logic [XLEN-1:0] dec_imm;
  imm_fmt_t        dec_fmt;
  logic            dec_illegal;
  logic            accept;

  imm_decode #(.XLEN(XLEN)) u_decode (
    .instr_i   (in_instr),
    .imm_o     (dec_imm),
    .fmt_o     (dec_fmt),
    .illegal_o (dec_illegal)
  );

  assign dec_res  = '{imm: dec_imm, fmt: dec_fmt, illegal: dec_illegal, tag: in_tag};
  assign in_ready = (state_q != ST_FULL) && !rst;
  assign accept   = in_valid && in_ready;

  // M always drives the outputs; K only catches the word accepted while M is stalled
  always_comb begin
    state_d = state_q;
    m_d     = m_q;
    k_d     = k_q;
    case (state_q)
      ST_EMPTY: begin
        if (accept) begin
          m_d     = dec_res;
          state_d = ST_ONE;
        end
      end
      ST_ONE: begin
        if (out_ready) begin
          if (accept) m_d = dec_res;
          else        state_d = ST_EMPTY;
        end else if (accept) begin
          k_d     = dec_res;
          state_d = ST_FULL;
        end
      end
      ST_FULL: begin
        if (out_ready) begin
          m_d     = k_q;
          state_d = ST_ONE;
        end
      end
      default: state_d = ST_EMPTY;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_EMPTY;
      m_q     <= '0;
      k_q     <= '0;
    end else begin
      state_q <= state_d;
      m_q     <= m_d;
      k_q     <= k_d;
    end
  end

  assign out_valid   = (state_q != ST_EMPTY);
  assign out_imm     = m_q.imm;
  assign out_fmt     = m_q.fmt;
  assign out_illegal = m_q.illegal;
  assign out_tag     = m_q.tag;

endmodule
